// File: rtl/usr_sequencer.sv
// Command sequencer for the 4-bit universal shift register: expands one
// accepted command into a per-cycle select/data pattern and pulses done at the end.
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] p_din,
    output logic             s_left_din,
    output logic             s_right_din,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

    // Counter is one bit wider so a zero count field can represent 2^CNT_W.
    localparam logic [CNT_W:0] ONE_COUNT  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] FULL_COUNT = {1'b1, {CNT_W{1'b0}}};

    state_t           state;
    logic [2:0]       op;
    logic [CNT_W:0]   cnt;
    logic             err_flag;
    logic             sl_reg;
    logic             sr_reg;
    logic [CNT_W:0]   eff_count;
    logic [1:0]       run_select;

    always_comb begin
        eff_count = {1'b0, cmd_count};
        if (cmd_op == OP_LOAD) begin
            eff_count = ONE_COUNT;
        end else if (cmd_count == '0) begin
            eff_count = FULL_COUNT;
        end
    end

    always_comb begin
        run_select = SEL_HOLD;
        case (cmd_op)
            OP_LOAD:        run_select = SEL_LOAD;
            OP_SHR, OP_ROR: run_select = SEL_RIGHT;
            OP_SHL, OP_ROL: run_select = SEL_LEFT;
            default:        run_select = SEL_HOLD;
        endcase
    end

    // Outputs are set on the entry edge so the pattern is present for the whole
    // first RUN cycle; the counter counts RUN cycles, leaving RUN when it hits one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= OP_NOP;
            cnt      <= '0;
            err_flag <= 1'b0;
            select   <= SEL_HOLD;
            p_din    <= '0;
            sl_reg   <= 1'b0;
            sr_reg   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state    <= RUN;
                        op       <= cmd_op;
                        cnt      <= eff_count;
                        err_flag <= (cmd_op > OP_ROL);
                        select   <= run_select;
                        if (cmd_op == OP_LOAD) begin
                            p_din <= cmd_data;
                        end
                        sl_reg   <= (cmd_op == OP_SHL) & cmd_fill;
                        sr_reg   <= (cmd_op == OP_SHR) & cmd_fill;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == ONE_COUNT) begin
                        state  <= DONE;
                        select <= SEL_HOLD;
                        sl_reg <= 1'b0;
                        sr_reg <= 1'b0;
                        done   <= 1'b1;
                        err    <= err_flag;
                    end else begin
                        cnt <= cnt - ONE_COUNT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = rst_n & (state == IDLE);

    // Rotates feed back the live register value so every edge sees the current bit.
    assign s_left_din  = (state == RUN && op == OP_ROL) ? usr_q[WIDTH-1] : sl_reg;
    assign s_right_din = (state == RUN && op == OP_ROR) ? usr_q[0]       : sr_reg;

endmodule
